// File: rtl/i2c_wr_sched_pkg.sv
// rtl/i2c_wr_sched_pkg.sv - shared state encodings, I2C constants and ring-index helper
package i2c_wr_sched_pkg;

  localparam int   I2C_ADDR_W = 7;
  localparam logic I2C_WR_BIT = 1'b0;

  // One-hot so each state decode is a single flop bit
  typedef enum logic [6:0] {
    ST_IDLE = 7'b0000001,
    ST_ARB  = 7'b0000010,
    ST_DEV  = 7'b0000100,
    ST_REG  = 7'b0001000,
    ST_DAT  = 7'b0010000,
    ST_FIN  = 7'b0100000,
    ST_ABT  = 7'b1000000
  } state_e;

  // Fold an index that may have run one lap past n back into 0..n-1
  function automatic int rr_wrap(input int a, input int n);
    return (a >= n) ? (a - n) : a;
  endfunction

endpackage

// File: rtl/i2c_rr_arb.sv
// rtl/i2c_rr_arb.sv - round-robin winner select with registered rotating pointer
module i2c_rr_arb
  import i2c_wr_sched_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            upd,
  output logic [NREQ-1:0] gnt_oh,
  output logic [PW-1:0]   win_idx,
  output logic            any
);

  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic          found;

  // Scan from rr_ptr upward with wrap; the first set request wins
  always_comb begin
    gnt_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      if (!found && req[rr_wrap(int'(rr_ptr_q) + off, NREQ)]) begin
        found   = 1'b1;
        gnt_oh[rr_wrap(int'(rr_ptr_q) + off, NREQ)] = 1'b1;
        win_idx = PW'(rr_wrap(int'(rr_ptr_q) + off, NREQ));
      end
    end
  end

  assign any = found;

  // After a grant the pointer moves just past the winner so it becomes lowest priority
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (upd && found) begin
      rr_ptr_d = (win_idx == PW'(NREQ - 1)) ? '0 : (win_idx + PW'(1));
    end
  end

  // Pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/i2c_wr_sched.sv
// rtl/i2c_wr_sched.sv - round-robin I2C register-write scheduler; I2C_TIMEOUT_EN adds a per-byte watchdog
module i2c_wr_sched
  import i2c_wr_sched_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int TO_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*I2C_ADDR_W-1:0] req_dev,
  input  logic [NREQ*8-1:0]          req_reg,
  input  logic [NREQ*8-1:0]          req_dat,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            done,
  output logic [NREQ-1:0]            err,
  output logic                       busy,
  output logic                       tx_ready,
  output logic [7:0]                 tx_data,
  input  logic                       tx_done,
  input  logic                       tx_nack
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e                state_q, state_d;
  logic [NREQ-1:0]       gnt_q, gnt_d;
  logic [NREQ-1:0]       done_q, done_d;
  logic [NREQ-1:0]       err_q, err_d;
  logic                  tx_ready_q, tx_ready_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic [I2C_ADDR_W-1:0] dev_q, dev_d;
  logic [7:0]            reg_q, reg_d;
  logic [7:0]            dat_q, dat_d;
  logic                  tx_done_q, tx_done_d;

  logic                  tx_edge;
  logic                  byte_st;
  logic                  wd_expire;
  logic                  arb_upd;
  logic                  arb_any;
  logic [NREQ-1:0]       arb_gnt;
  logic [PW-1:0]         arb_idx;
  logic [I2C_ADDR_W-1:0] win_dev;
  logic [7:0]            win_reg;
  logic [7:0]            win_dat;

  i2c_rr_arb #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .upd     (arb_upd),
    .gnt_oh  (arb_gnt),
    .win_idx (arb_idx),
    .any     (arb_any)
  );

  assign win_dev = req_dev[int'(arb_idx)*I2C_ADDR_W +: I2C_ADDR_W];
  assign win_reg = req_reg[int'(arb_idx)*8 +: 8];
  assign win_dat = req_dat[int'(arb_idx)*8 +: 8];

  // A level already high on byte-state entry is not an edge; only a fresh rise counts
  assign tx_done_d = tx_done;
  assign tx_edge   = tx_done & ~tx_done_q;
  assign byte_st   = (state_q == ST_DEV) || (state_q == ST_REG) || (state_q == ST_DAT);

`ifdef I2C_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYCLES + 1);
  logic [TW-1:0] wd_q, wd_d;

  // Watchdog restarts with each byte strobe and counts while waiting for tx_done
  always_comb begin
    wd_d = wd_q;
    if (tx_ready_d) begin
      wd_d = '0;
    end else if (byte_st) begin
      wd_d = wd_q + TW'(1);
    end
  end

  // Watchdog register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end

  assign wd_expire = (wd_q == TW'(TO_CYCLES - 1));
`else
  logic unused_to_cycles;
  assign unused_to_cycles = (TO_CYCLES != 0);
  assign wd_expire        = 1'b0;
`endif

  // Transaction FSM: arbitrate, strobe three bytes, then report done or err for one cycle
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    err_d      = '0;
    tx_ready_d = 1'b0;
    tx_data_d  = tx_data_q;
    dev_d      = dev_q;
    reg_d      = reg_q;
    dat_d      = dat_q;
    arb_upd    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) state_d = ST_ARB;
      end
      ST_ARB: begin
        // The requester may have dropped since IDLE; with nobody left, go back quietly
        if (arb_any) begin
          arb_upd    = 1'b1;
          gnt_d      = arb_gnt;
          dev_d      = win_dev;
          reg_d      = win_reg;
          dat_d      = win_dat;
          tx_ready_d = 1'b1;
          tx_data_d  = {win_dev, I2C_WR_BIT};
          state_d    = ST_DEV;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DEV, ST_REG, ST_DAT: begin
        if (tx_edge) begin
          if (tx_nack) begin
            err_d   = gnt_q;
            state_d = ST_ABT;
          end else if (state_q == ST_DEV) begin
            tx_ready_d = 1'b1;
            tx_data_d  = reg_q;
            state_d    = ST_REG;
          end else if (state_q == ST_REG) begin
            tx_ready_d = 1'b1;
            tx_data_d  = dat_q;
            state_d    = ST_DAT;
          end else begin
            done_d  = gnt_q;
            state_d = ST_FIN;
          end
        end else if (wd_expire) begin
          err_d   = gnt_q;
          state_d = ST_ABT;
        end
      end
      ST_FIN, ST_ABT: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, operand and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      done_q     <= '0;
      err_q      <= '0;
      tx_ready_q <= 1'b0;
      tx_data_q  <= 8'h00;
      dev_q      <= '0;
      reg_q      <= 8'h00;
      dat_q      <= 8'h00;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      tx_ready_q <= tx_ready_d;
      tx_data_q  <= tx_data_d;
      dev_q      <= dev_d;
      reg_q      <= reg_d;
      dat_q      <= dat_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign err      = err_q;
  assign busy     = (state_q != ST_IDLE);
  assign tx_ready = tx_ready_q;
  assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_i2c_wr_sched.sv
// tb/tb_i2c_wr_sched.sv - directed self-checking bench for i2c_wr_sched
module tb_i2c_wr_sched;

  localparam int NREQ = 4;

  logic            clk;
  logic            rst_n;
  logic [NREQ-1:0] req;
  logic [NREQ*7-1:0] req_dev;
  logic [NREQ*8-1:0] req_reg;
  logic [NREQ*8-1:0] req_dat;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] done;
  logic [NREQ-1:0] err;
  logic            busy;
  logic            tx_ready;
  logic [7:0]      tx_data;
  logic            tx_done;
  logic            tx_nack;

  logic [6:0] dev_a [NREQ];
  logic [7:0] reg_a [NREQ];
  logic [7:0] dat_a [NREQ];

  int n_cmp = 0;
  int n_mis = 0;

  i2c_wr_sched #(.NREQ(NREQ), .TO_CYCLES(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_dev  (req_dev),
    .req_reg  (req_reg),
    .req_dat  (req_dat),
    .gnt      (gnt),
    .done     (done),
    .err      (err),
    .busy     (busy),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .tx_nack  (tx_nack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_strobe(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (tx_ready) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  // One engine byte slot: tx_done high for a single cycle
  task automatic ack_byte(input bit nack);
    @(negedge clk);
    tx_done = 1'b1;
    tx_nack = nack;
    @(negedge clk);
    tx_done = 1'b0;
    tx_nack = 1'b0;
  endtask

  // Full transaction for requester idx; nack_byte 0..2 NACKs that byte, 3 acks all
  task automatic serve(input int idx, input int nack_byte, input string tag);
    logic [7:0] exp_b [3];
    bit ok;
    exp_b[0] = {dev_a[idx], 1'b0};
    exp_b[1] = reg_a[idx];
    exp_b[2] = dat_a[idx];
    for (int b = 0; b < 3; b++) begin
      wait_strobe(ok);
      check($sformatf("%s_b%0d_strobe", tag, b), 32'(ok), 32'd1);
      if (!ok) return;
      check($sformatf("%s_b%0d_data", tag, b), 32'(tx_data), 32'(exp_b[b]));
      check($sformatf("%s_b%0d_gnt", tag, b), 32'(gnt), 32'(1 << idx));
      ack_byte(b == nack_byte);
      if (b == nack_byte) begin
        check({tag, "_err"}, 32'(err), 32'(1 << idx));
        check({tag, "_nodone"}, 32'(done), 32'd0);
        check({tag, "_nostrobe"}, 32'(tx_ready), 32'd0);
        @(negedge clk);
        check({tag, "_busy_fall"}, 32'(busy), 32'd0);
        check({tag, "_err_pulse"}, 32'(err), 32'd0);
        return;
      end
    end
    check({tag, "_done"}, 32'(done), 32'(1 << idx));
    check({tag, "_noerr"}, 32'(err), 32'd0);
    @(negedge clk);
    check({tag, "_idle_gap"}, 32'(busy), 32'd0);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_gnt_clr"}, 32'(gnt), 32'd0);
  endtask

  initial begin
    bit ok;
    dev_a = '{7'h50, 7'h21, 7'h3C, 7'h7F};
    reg_a = '{8'h10, 8'h22, 8'h33, 8'h44};
    dat_a = '{8'hA5, 8'h5A, 8'hC3, 8'h0F};
    for (int i = 0; i < NREQ; i++) begin
      req_dev[7*i +: 7] = dev_a[i];
      req_reg[8*i +: 8] = reg_a[i];
      req_dat[8*i +: 8] = dat_a[i];
    end
    rst_n   = 1'b0;
    req     = '0;
    tx_done = 1'b0;
    tx_nack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_done_err", 32'({done, err}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: single requester, latency and byte contents
    req = 4'b0001;
    @(negedge clk);
    check("t1_arb_noready", 32'(tx_ready), 32'd0);
    check("t1_arb_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("t1_latency", 32'(tx_ready), 32'd1);
    serve(0, 3, "t1");
    req = '0;

    // Test 2: all requesting from rr_ptr=0 -> 0,1,2,3,0
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1111;
    serve(0, 3, "t2_0");
    serve(1, 3, "t2_1");
    serve(2, 3, "t2_2");
    serve(3, 3, "t2_3");
    serve(0, 3, "t2_4");
    req = '0;
    repeat (2) @(negedge clk);

    // Test 3: NACK on REG byte for requester 2
    req = 4'b0100;
    serve(2, 1, "t3");
    req = '0;
    repeat (3) @(negedge clk);
    check("t3_stay_idle", 32'({busy, tx_ready}), 32'd0);

    // Test 4: tx_done already high on DEV entry; stray tx_nack without an edge
    tx_done = 1'b1;
    req = 4'b0010;
    wait_strobe(ok);
    check("t4_strobe", 32'(ok), 32'd1);
    check("t4_dev", 32'(tx_data), 32'(8'h42));
    tx_nack = 1'b1;
    repeat (3) @(negedge clk);
    check("t4_hold_ready", 32'(tx_ready), 32'd0);
    check("t4_hold_data", 32'(tx_data), 32'(8'h42));
    check("t4_hold_busy_err", 32'({busy, err}), 32'h10);
    tx_nack = 1'b0;
    tx_done = 1'b0;
    ack_byte(1'b0);
    wait_strobe(ok);
    check("t4_reg", 32'(tx_data), 32'(8'h22));
    ack_byte(1'b0);
    wait_strobe(ok);
    check("t4_dat", 32'(tx_data), 32'(8'h5A));
    ack_byte(1'b0);
    check("t4_done", 32'(done), 32'h2);
    @(negedge clk);
    req = '0;
    @(negedge clk);

    // Test 5: async reset during REG wait, then a clean restart from DEV
    req = 4'b1000;
    wait_strobe(ok);
    ack_byte(1'b0);
    check("t5_reg_strobe", 32'({tx_ready, tx_data}), 32'h144);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_rst_gnt", 32'(gnt), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_tx", 32'({tx_ready, tx_data}), 32'd0);
    check("t5_rst_done_err", 32'({done, err}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    serve(3, 3, "t5");
    req = '0;
    @(negedge clk);

    // Test 6: engine never answers
    req = 4'b0001;
    wait_strobe(ok);
    check("t6_strobe", 32'(ok), 32'd1);
`ifdef I2C_TIMEOUT_EN
    repeat (15) @(negedge clk);
    check("t6_err_early", 32'(err), 32'd0);
    @(negedge clk);
    check("t6_err_timeout", 32'(err), 32'h1);
    req = '0;
    @(negedge clk);
    check("t6_busy_fall", 32'(busy), 32'd0);
`else
    repeat (40) @(negedge clk);
    check("t6_busy_wait", 32'(busy), 32'd1);
    check("t6_no_err", 32'(err), 32'd0);
    ack_byte(1'b0);
    wait_strobe(ok);
    check("t6_reg", 32'(tx_data), 32'(8'h10));
    ack_byte(1'b0);
    wait_strobe(ok);
    ack_byte(1'b0);
    check("t6_done", 32'(done), 32'h1);
    req = '0;
    @(negedge clk);
    check("t6_busy_fall", 32'(busy), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
